// File: rtl/jtag_uart_sys_pkg.sv
`default_nettype none
// ============================================================
// Module  : jtag_uart_sys_pkg
// Brief   : shared state, command and helper definitions
// Revision: 1.0
// ============================================================
package jtag_uart_sys_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_WDATA  = 3'd2,
        ST_WFLUSH = 3'd3,
        ST_ACK    = 3'd4,
        ST_RREQ   = 3'd5,
        ST_RWAIT  = 3'd6,
        ST_RSEND  = 3'd7
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam int         HDR_LEN   = 4;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[8*lane +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_uart_sys_byte_packer.sv
`default_nettype none
// ============================================================
// Module  : jtag_uart_sys_byte_packer
// Brief   : little-endian lane registers, byte-enable mask, flush request
// Revision: 1.0
// ============================================================
module jtag_uart_sys_byte_packer
    import jtag_uart_sys_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_accept,
    input  logic [1:0]  i_lane,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    input  logic        i_clear,
    output logic [31:0] o_wbuf_nxt,
    output logic [3:0]  o_be_nxt,
    output logic        o_flush_req
);

    logic [31:0] r_wbuf;
    logic [3:0]  r_be;

    // Next-cycle view is exported so the flush write can include the byte accepted this cycle.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic w_hit;
        assign w_hit                  = i_accept && (i_lane == 2'(l));
        assign o_wbuf_nxt[8*l +: 8]   = w_hit ? i_byte : r_wbuf[8*l +: 8];
        assign o_be_nxt[l]            = w_hit | r_be[l];
    end

    assign o_flush_req = i_accept && ((i_lane == 2'd3) || i_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wbuf <= '0;
            r_be   <= '0;
        end else begin
            r_wbuf <= o_wbuf_nxt;
            r_be   <= i_clear ? 4'b0000 : o_be_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_uart_sys_mem_loader.sv
`default_nettype none
// ============================================================
// Module  : jtag_uart_sys_mem_loader
// Brief   : framed byte-command engine loading/dumping on-chip RAM
// Revision: 1.0
// ============================================================
module jtag_uart_sys_mem_loader
    import jtag_uart_sys_pkg::*;
#(
    parameter int         ADDR_W   = 11,
    parameter logic [7:0] ACK_BYTE = 8'h4B
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              err
);

    localparam int                c_ba_w     = ADDR_W + 2;
    localparam logic [c_ba_w-1:0] c_addr_one = 1;
    localparam logic [ADDR_W-1:0] c_word_one = 1;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_hdr_cnt;
    logic                r_is_write;
    logic [c_ba_w-1:0]   r_addr;
    logic [15:0]         r_len;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic                r_rx_ready;

    logic [ADDR_W-1:0]   r_mem_address;
    logic [3:0]          r_mem_be;
    logic                r_mem_cs;
    logic                r_mem_we;
    logic [31:0]         r_mem_wdata;

    logic                w_rx_fire;
    logic                w_cmd_known;
    logic [15:0]         w_len_full;
    logic                w_last;
    logic                w_accept;
    logic                w_flush_req;
    logic [31:0]         w_wbuf_nxt;
    logic [3:0]          w_be_nxt;
    logic [ADDR_W-1:0]   w_rd_word;
    logic [7:0]          w_tx_data;
    logic                w_tx_valid;

    assign w_rx_fire   = rx_valid && r_rx_ready;
    assign w_cmd_known = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_last      = (r_len == 16'd1);
    assign w_accept    = (r_state == ST_WDATA) && w_rx_fire;
    // A re-request from RSEND always follows lane 3, so it targets the next word.
    assign w_rd_word   = (r_state == ST_RSEND) ? (r_addr[c_ba_w-1:2] + c_word_one)
                                               : r_addr[c_ba_w-1:2];

    jtag_uart_sys_byte_packer u_packer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_accept    (w_accept),
        .i_lane      (r_addr[1:0]),
        .i_byte      (rx_data),
        .i_last      (w_last),
        .i_clear     (r_state == ST_WFLUSH),
        .o_wbuf_nxt  (w_wbuf_nxt),
        .o_be_nxt    (w_be_nxt),
        .o_flush_req (w_flush_req)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire && w_cmd_known) w_state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (w_rx_fire && (r_hdr_cnt == 2'(HDR_LEN - 1))) begin
                    if (w_len_full == 16'd0) w_state_nxt = r_is_write ? ST_ACK : ST_IDLE;
                    else                     w_state_nxt = r_is_write ? ST_WDATA : ST_RREQ;
                end
            end
            ST_WDATA:  if (w_flush_req) w_state_nxt = ST_WFLUSH;
            ST_WFLUSH: w_state_nxt = (r_len == 16'd0) ? ST_ACK : ST_WDATA;
            ST_ACK:    if (tx_ready) w_state_nxt = ST_IDLE;
            ST_RREQ:   w_state_nxt = ST_RWAIT;
            ST_RWAIT:  w_state_nxt = ST_RSEND;
            ST_RSEND: begin
                if (tx_ready) begin
                    if (w_last)                    w_state_nxt = ST_IDLE;
                    else if (r_addr[1:0] == 2'd3)  w_state_nxt = ST_RREQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
        case (r_state)
            ST_ACK: begin
                w_tx_valid = 1'b1;
                w_tx_data  = ACK_BYTE;
            end
            ST_RSEND: begin
                w_tx_valid = 1'b1;
                w_tx_data  = lane_byte(r_rdata, r_addr[1:0]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_hdr_cnt  <= '0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_rx_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Registered so rx_ready reads 0 while reset is held.
            r_rx_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HDR) ||
                          (w_state_nxt == ST_WDATA);
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_fire) begin
                        r_is_write <= (rx_data == CMD_WRITE);
                        r_hdr_cnt  <= '0;
                        r_err      <= !w_cmd_known;
                    end
                end
                ST_HDR: begin
                    if (w_rx_fire) begin
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                        case (r_hdr_cnt)
                            2'd0:    r_addr[7:0]        <= rx_data;
                            2'd1:    r_addr[c_ba_w-1:8] <= rx_data[c_ba_w-9:0];
                            2'd2:    r_len[7:0]         <= rx_data;
                            default: r_len[15:8]        <= rx_data;
                        endcase
                    end
                end
                ST_WDATA: begin
                    if (w_rx_fire) begin
                        r_addr <= r_addr + c_addr_one;
                        r_len  <= r_len - 16'd1;
                    end
                end
                ST_RWAIT: r_rdata <= mem_readdata;
                ST_RSEND: begin
                    if (tx_ready) begin
                        r_addr <= r_addr + c_addr_one;
                        r_len  <= r_len - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_address <= '0;
            r_mem_be      <= '0;
            r_mem_cs      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= '0;
        end else begin
            r_mem_cs <= 1'b0;
            r_mem_we <= 1'b0;
            if (w_flush_req) begin
                r_mem_cs      <= 1'b1;
                r_mem_we      <= 1'b1;
                r_mem_address <= r_addr[c_ba_w-1:2];
                r_mem_be      <= w_be_nxt;
                r_mem_wdata   <= w_wbuf_nxt;
            end else if (w_state_nxt == ST_RREQ) begin
                r_mem_cs      <= 1'b1;
                r_mem_we      <= 1'b0;
                r_mem_address <= w_rd_word;
                r_mem_be      <= 4'hF;
            end
        end
    end

    assign rx_ready       = r_rx_ready;
    assign tx_valid       = w_tx_valid;
    assign tx_data        = w_tx_data;
    assign mem_address    = r_mem_address;
    assign mem_byteenable = r_mem_be;
    assign mem_chipselect = r_mem_cs;
    assign mem_write      = r_mem_we;
    assign mem_writedata  = r_mem_wdata;
    assign mem_clken      = 1'b1;
    assign err            = r_err;

endmodule
`default_nettype wire
